pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and stall controller for the 5-stage RISC-V pipeline.
- Owns the per-stage valid tracking and the load-use stall sequencing.
- Handles branch/jump flush, cache-busywait freeze and EX-operand forwarding selects.
- Sits beside the pipeline registers and drives their write-enable and flush controls, plus the PC write enable.

Parameters:
- REG_ADDR_W, 5, register address width.
- STAGES, 5, number of pipeline stages tracked (IF=0 … WB=STAGES-1); minimum 5.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- FLUSH_DEPTH, 2, number of youngest stages invalidated on a taken branch/jump (1..STAGES-2).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- instrCache_busywait  in  1  instruction cache stall.
- dataCache_busywait  in  1  data cache stall.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers in ID.
- id_uses_rs1, id_uses_rs2  in  1  source-register-used flags.
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers in EX.
- ex_rd  in  REG_ADDR_W  destination register in EX.
- ex_memRead, ex_regWrite  in  1  EX control bits.
- mem_rd  in  REG_ADDR_W  destination register in MEM.
- mem_regWrite  in  1  MEM control bit.
- wb_rd  in  REG_ADDR_W  destination register in WB.
- wb_regWrite  in  1  WB control bit.
- branch_taken  in  1  pcmux_select from EX.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_bubble  out  1  zero the control bits entering EX.
- freeze  out  1  hold all pipeline registers.
- fwd_a_sel, fwd_b_sel  out  2  00 = regfile, 01 = MEM result, 10 = WB result.
- stage_valid  out  STAGES  per-stage valid; bit 0 = IF.

Behaviour:
- All inputs are sampled on the rising CLK edge. Control outputs are combinational from inputs and internal state. stage_valid and bubble_cnt are registers.
- Priority, highest first: RESET > freeze > branch flush > load-use stall > normal.
- RESET held:
  - stage_valid = 0, bubble_cnt = 0.
  - pc_write = 0, if_id_write = 0, if_id_flush = 1, id_ex_bubble = 1, freeze = 0, fwd selects = 00.
  - Reset asserted mid-stall or mid-flush discards all pending state.
- freeze = instrCache_busywait | dataCache_busywait.
  - While frozen: pc_write = 0, if_id_write = 0, flush and bubble outputs = 0.
  - stage_valid and bubble_cnt hold.
  - branch_taken is ignored while frozen. EX is frozen, so the flush takes effect on the first unfrozen cycle.
- Normal cycle: pc_write = 1, if_id_write = 1; stage_valid shifts up (valid[i] <= valid[i-1]) and valid[0] <= 1.
- Branch flush (branch_taken, not frozen):
  - pc_write = 1, if_id_flush = 1, id_ex_bubble = 1.
  - After the shift, stage_valid bits 0..FLUSH_DEPTH-1 are cleared, except that bit 0 is reloaded with 1 for the target fetch.
  - bubble_cnt is cleared, which cancels any pending load-use stall.
- Load-use hazard:
  - Detected when ex_memRead & ex_regWrite & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)), with no flush and no freeze.
  - Response: pc_write = 0, if_id_write = 0, id_ex_bubble = 1. The EX valid bit receives 0 and IF/ID valid bits hold.
  - bubble_cnt loads LOAD_USE_BUBBLES-1.
  - While bubble_cnt > 0 (not frozen): same stall outputs, and bubble_cnt decrements each cycle.
  - A new hazard detected while bubble_cnt > 0 does not reload the counter.
- Forwarding, per operand (shown for A; B is identical using ex_rs2):
  - 01 if mem_regWrite & mem_rd != 0 & mem_rd == ex_rs1 & stage_valid[3].
  - Else 10 if wb_regWrite & wb_rd != 0 & wb_rd == ex_rs1 & stage_valid[4].
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.
- Latency: a stall decision takes effect on the same cycle as detection; state updates on the next edge.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- Defined: adds 32-bit outputs stall_cycles, flush_count and freeze_cycles.
  - stall_cycles increments on each load-use stall cycle.
  - flush_count increments on each accepted branch flush.
  - freeze_cycles increments on each frozen cycle.
  - All three reset to 0, wrap at 2^32 and hold while RESET is asserted.
- Undefined: the outputs and counters are absent; no other behaviour changes.

Test Plan:
- Reset: RESET = 1 for 2 cycles, then 0 -> stage_valid goes 00000, 00001, 00011 … 11111 after 5 cycles; pc_write = 1 from the first released cycle.
- Load-use, LOAD_USE_BUBBLES = 1: ex_rd = 5, ex_memRead = 1, ex_regWrite = 1, id_rs1 = 5, id_uses_rs1 = 1 -> exactly 1 cycle of pc_write = 0, id_ex_bubble = 1; stage_valid[2] = 0 next cycle.
- Load-use, LOAD_USE_BUBBLES = 2: same stimulus -> exactly 2 stall cycles. With ex_rd = 0 -> no stall.
- Branch during freeze: branch_taken = 1 with dataCache_busywait = 1 for 3 cycles -> no flush; flush asserts on the 4th cycle; stage_valid[1:0] = 01 afterwards.
- Branch during load-use stall, LOAD_USE_BUBBLES = 3: branch_taken asserted in the second stall cycle -> flush that cycle, bubble_cnt = 0, pc_write = 1.
- Forwarding: ex_rs1 = 7, mem_rd = 7, wb_rd = 7, both regWrite set -> fwd_a_sel = 01. With mem_regWrite = 0 -> 10. With rd = 0 -> 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RISC-V pipeline: stage valid tracking, load-use
// stalls, branch flush, cache freeze and EX forwarding. Perf counters: HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W       = 5,
    parameter int STAGES           = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FLUSH_DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  instrCache_busywait,
    input  logic                  dataCache_busywait,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_regWrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regWrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regWrite,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  freeze,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [STAGES-1:0]     stage_valid
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
    output logic [31:0]           freeze_cycles
`endif
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0]      BUBBLE_LOAD = CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [STAGES-1:0]     FLUSH_MASK  = STAGES'((1 << FLUSH_DEPTH) - 1);
    localparam logic [REG_ADDR_W-1:0] REG_X0      = {REG_ADDR_W{1'b0}};

    typedef enum logic [2:0] {
        MODE_RESET  = 3'd0,
        MODE_FREEZE = 3'd1,
        MODE_FLUSH  = 3'd2,
        MODE_STALL  = 3'd3,
        MODE_NORMAL = 3'd4
    } mode_t;

    // MEM result beats WB result; x0 and invalid stages never forward.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic                  m_valid,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we,
        input logic                  w_valid
    );
        logic [1:0] sel;
        if (m_we && (m_rd != REG_X0) && (m_rd == rs) && m_valid) begin
            sel = 2'b01;
        end else if (w_we && (w_rd != REG_X0) && (w_rd == rs) && w_valid) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [STAGES-1:0] stage_valid_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [STAGES-1:0] valid_next_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              freeze_s;
    logic              hazard_s;
    mode_t             mode_s;

    assign stage_valid = stage_valid_r;
    assign freeze_s    = instrCache_busywait | dataCache_busywait;
    assign hazard_s    = ex_memRead & ex_regWrite & (ex_rd != REG_X0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Resolve the cycle's operating mode in priority order.
    always_comb begin
        mode_s = MODE_NORMAL;
        if (RESET) begin
            mode_s = MODE_RESET;
        end else if (freeze_s) begin
            mode_s = MODE_FREEZE;
        end else if (branch_taken) begin
            mode_s = MODE_FLUSH;
        end else if (hazard_s || (bubble_cnt_r != CNT_ZERO)) begin
            mode_s = MODE_STALL;
        end else begin
            mode_s = MODE_NORMAL;
        end
    end

    // Pipeline register controls and forwarding selects.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;
        fwd_a_sel    = fwd_sel(ex_rs1, mem_rd, mem_regWrite, stage_valid_r[3],
                               wb_rd, wb_regWrite, stage_valid_r[4]);
        fwd_b_sel    = fwd_sel(ex_rs2, mem_rd, mem_regWrite, stage_valid_r[3],
                               wb_rd, wb_regWrite, stage_valid_r[4]);
        case (mode_s)
            MODE_RESET: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                fwd_a_sel    = 2'b00;
                fwd_b_sel    = 2'b00;
            end
            MODE_FREEZE: begin
                freeze = 1'b1;
            end
            MODE_FLUSH: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            MODE_STALL: begin
                id_ex_bubble = 1'b1;
            end
            MODE_NORMAL: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
            default: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        endcase
    end

    // Next stage-valid vector and bubble counter for each mode.
    always_comb begin
        valid_next_s = {stage_valid_r[STAGES-2:0], 1'b1};
        cnt_next_s   = bubble_cnt_r;
        case (mode_s)
            MODE_RESET: begin
                valid_next_s = {STAGES{1'b0}};
                cnt_next_s   = CNT_ZERO;
            end
            MODE_FREEZE: begin
                valid_next_s = stage_valid_r;
            end
            MODE_FLUSH: begin
                // Younger stages are squashed; IF restarts at the branch target.
                valid_next_s = ({stage_valid_r[STAGES-2:0], 1'b1} & ~FLUSH_MASK) |
                               {{(STAGES-1){1'b0}}, 1'b1};
                cnt_next_s   = CNT_ZERO;
            end
            MODE_STALL: begin
                valid_next_s = {stage_valid_r[STAGES-2:2], 1'b0, stage_valid_r[1:0]};
                if (bubble_cnt_r == CNT_ZERO) begin
                    cnt_next_s = BUBBLE_LOAD;
                end else begin
                    cnt_next_s = bubble_cnt_r - CNT_W'(1);
                end
            end
            MODE_NORMAL: begin
                valid_next_s = {stage_valid_r[STAGES-2:0], 1'b1};
            end
            default: begin
                valid_next_s = {STAGES{1'b0}};
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Stage valid and bubble counter state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_valid_r <= {STAGES{1'b0}};
            bubble_cnt_r  <= CNT_ZERO;
        end else begin
            stage_valid_r <= valid_next_s;
            bubble_cnt_r  <= cnt_next_s;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;
    logic [31:0] freeze_cycles_r;

    assign stall_cycles  = stall_cycles_r;
    assign flush_count   = flush_count_r;
    assign freeze_cycles = freeze_cycles_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cycles_r  <= 32'd0;
            flush_count_r   <= 32'd0;
            freeze_cycles_r <= 32'd0;
        end else begin
            if (mode_s == MODE_STALL) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (mode_s == MODE_FLUSH) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
            if (mode_s == MODE_FREEZE) begin
                freeze_cycles_r <= freeze_cycles_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (LOAD_USE_BUBBLES 1..3) checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ic_busy, dc_busy;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_regWrite;
    logic       mem_regWrite, wb_regWrite, branch_taken;

    logic [2:0] pc_w, ifid_w, ifid_f, bub, frz;
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic [4:0] sv [3];
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] c_stall [3];
    logic [31:0] c_flush [3];
    logic [31:0] c_frz   [3];
    int unsigned m_stall [3];
    int unsigned m_flush [3];
    int unsigned m_frz   [3];
`endif

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_hazard_ctrl #(
            .REG_ADDR_W(5), .STAGES(5), .LOAD_USE_BUBBLES(g + 1), .FLUSH_DEPTH((g == 2) ? 3 : 2)
        ) u_dut (
            .CLK(CLK), .RESET(RESET),
            .instrCache_busywait(ic_busy), .dataCache_busywait(dc_busy),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
            .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
            .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
            .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
            .wb_rd(wb_rd), .wb_regWrite(wb_regWrite), .branch_taken(branch_taken),
            .pc_write(pc_w[g]), .if_id_write(ifid_w[g]), .if_id_flush(ifid_f[g]),
            .id_ex_bubble(bub[g]), .freeze(frz[g]),
            .fwd_a_sel(fa[g]), .fwd_b_sel(fb[g]), .stage_valid(sv[g])
`ifdef HAZARD_PERF_COUNTERS_EN
            , .stall_cycles(c_stall[g]), .flush_count(c_flush[g]), .freeze_cycles(c_frz[g])
`endif
        );
    end

    task automatic check(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s inst%0d got=%0d expected=%0d at %0t", name, inst, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid [3][5];
    int m_cnt   [3];

    function automatic int fwd_model(input logic [4:0] rs, input bit v3, input bit v4);
        if (mem_regWrite && mem_rd != 5'd0 && mem_rd == rs && v3) return 1;
        if (wb_regWrite && wb_rd != 5'd0 && wb_rd == rs && v4) return 2;
        return 0;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int i = 0; i < 5; i++) m_valid[k][i] = 1'b0;
`ifdef HAZARD_PERF_COUNTERS_EN
            m_stall[k] = 0; m_flush[k] = 0; m_frz[k] = 0;
`endif
        end
        // Compare on every falling edge, then advance the model to the next rising edge.
        forever begin
            @(negedge CLK);
            if (done) break;
            for (int k = 0; k < 3; k++) begin
                int  lub, fd, mode, exp_sv;
                bit  haz, nv [5];
                lub = k + 1;
                fd  = (k == 2) ? 3 : 2;
                haz = ex_memRead && ex_regWrite && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
                if (RESET) mode = 0;
                else if (ic_busy || dc_busy) mode = 1;
                else if (branch_taken) mode = 2;
                else if (haz || m_cnt[k] > 0) mode = 3;
                else mode = 4;

                exp_sv = 0;
                for (int i = 0; i < 5; i++) exp_sv += int'(m_valid[k][i]) << i;
                check("stage_valid", k, int'(sv[k]), exp_sv);
                check("pc_write", k, int'(pc_w[k]), int'(mode == 2 || mode == 4));
                check("if_id_write", k, int'(ifid_w[k]), int'(mode == 2 || mode == 4));
                check("if_id_flush", k, int'(ifid_f[k]), int'(mode == 0 || mode == 2));
                check("id_ex_bubble", k, int'(bub[k]), int'(mode == 0 || mode == 2 || mode == 3));
                check("freeze", k, int'(frz[k]), int'(mode == 1));
                check("fwd_a_sel", k, int'(fa[k]),
                      (mode == 0) ? 0 : fwd_model(ex_rs1, m_valid[k][3], m_valid[k][4]));
                check("fwd_b_sel", k, int'(fb[k]),
                      (mode == 0) ? 0 : fwd_model(ex_rs2, m_valid[k][3], m_valid[k][4]));
`ifdef HAZARD_PERF_COUNTERS_EN
                check("stall_cycles", k, int'(c_stall[k]), int'(m_stall[k]));
                check("flush_count", k, int'(c_flush[k]), int'(m_flush[k]));
                check("freeze_cycles", k, int'(c_frz[k]), int'(m_frz[k]));
                if (mode == 0) begin
                    m_stall[k] = 0; m_flush[k] = 0; m_frz[k] = 0;
                end else begin
                    m_stall[k] += (mode == 3) ? 1 : 0;
                    m_flush[k] += (mode == 2) ? 1 : 0;
                    m_frz[k]   += (mode == 1) ? 1 : 0;
                end
`endif
                for (int i = 0; i < 5; i++) nv[i] = m_valid[k][i];
                case (mode)
                    0: begin
                        for (int i = 0; i < 5; i++) nv[i] = 1'b0;
                        m_cnt[k] = 0;
                    end
                    1: ;
                    2: begin
                        nv[0] = 1'b1;
                        for (int i = 1; i < 5; i++) nv[i] = (i < fd) ? 1'b0 : m_valid[k][i-1];
                        m_cnt[k] = 0;
                    end
                    3: begin
                        nv[2] = 1'b0;
                        for (int i = 3; i < 5; i++) nv[i] = m_valid[k][i-1];
                        m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : lub - 1;
                    end
                    default: begin
                        nv[0] = 1'b1;
                        for (int i = 1; i < 5; i++) nv[i] = m_valid[k][i-1];
                    end
                endcase
                for (int i = 0; i < 5; i++) m_valid[k][i] = nv[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        ic_busy = 1'b0; dc_busy = 1'b0; branch_taken = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_memRead = 1'b0; ex_regWrite = 1'b0;
        mem_rd = 5'd0; mem_regWrite = 1'b0; wb_rd = 5'd0; wb_regWrite = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_rd = rd; ex_memRead = 1'b1; ex_regWrite = 1'b1; id_rs1 = rd; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        int stall_n [3];
        int expv;
        RESET = 1'b1;
        idle_inputs();

        // Reset held for two cycles, then valid fills one stage per cycle.
        @(negedge CLK);
        check("reset_stage_valid", 0, int'(sv[0]), 0);
        check("reset_pc_write", 0, int'(pc_w[0]), 0);
        check("reset_if_id_flush", 0, int'(ifid_f[0]), 1);
        step();
        step();
        RESET = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge CLK);
            expv = (1 << i) - 1;
            check("fill_stage_valid", 0, int'(sv[0]), expv);
            if (i == 0) check("first_release_pc_write", 0, int'(pc_w[0]), 1);
            step();
        end

        // Load-use: one detection cycle then LOAD_USE_BUBBLES-1 counted bubbles.
        for (int k = 0; k < 3; k++) stall_n[k] = 0;
        set_load_use(5'd5);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) stall_n[k] += (pc_w[k] == 1'b0) ? 1 : 0;
            if (c == 0) check("load_use_bubble", 0, int'(bub[0]), 1);
            if (c == 1) check("ex_valid_after_stall", 0, int'(sv[0][2]), 0);
            step();
            idle_inputs();
        end
        for (int k = 0; k < 3; k++) check("load_use_stall_cycles", k, stall_n[k], k + 1);
        set_load_use(5'd0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) check("x0_no_stall", k, int'(pc_w[k]), 1);
        step();
        idle_inputs();

        // Branch held during a 3-cycle data-cache freeze; flush lands on the 4th.
        branch_taken = 1'b1;
        dc_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("frozen_freeze", 0, int'(frz[0]), 1);
            check("frozen_no_flush", 0, int'(ifid_f[0]), 0);
            check("frozen_pc_write", 0, int'(pc_w[0]), 0);
            step();
        end
        dc_busy = 1'b0;
        @(negedge CLK);
        check("unfrozen_flush", 0, int'(ifid_f[0]), 1);
        check("unfrozen_pc_write", 0, int'(pc_w[0]), 1);
        step();
        branch_taken = 1'b0;
        @(negedge CLK);
        check("post_flush_valid_1_0", 0, int'(sv[0][1:0]), 1);
        check("post_flush_valid_1_0", 1, int'(sv[1][1:0]), 1);
        step();
        for (int c = 0; c < 5; c++) step();

        // Branch in the second stall cycle of a 3-bubble load-use cancels the stall.
        set_load_use(5'd9);
        step();
        idle_inputs();
        branch_taken = 1'b1;
        @(negedge CLK);
        check("branch_in_stall_flush", 2, int'(ifid_f[2]), 1);
        check("branch_in_stall_pc", 2, int'(pc_w[2]), 1);
        step();
        branch_taken = 1'b0;
        @(negedge CLK);
        check("stall_cancelled_pc", 2, int'(pc_w[2]), 1);
        check("stall_cancelled_bubble", 2, int'(bub[2]), 0);
        step();
        for (int c = 0; c < 5; c++) step();

        // Forwarding priority and x0 suppression.
        ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
        mem_regWrite = 1'b1; wb_regWrite = 1'b1;
        @(negedge CLK);
        check("fwd_mem_priority", 0, int'(fa[0]), 1);
        check("fwd_b_mem_priority", 0, int'(fb[0]), 1);
        step();
        mem_regWrite = 1'b0;
        @(negedge CLK);
        check("fwd_wb", 0, int'(fa[0]), 2);
        step();
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regWrite = 1'b1;
        @(negedge CLK);
        check("fwd_x0", 0, int'(fa[0]), 0);
        step();
        idle_inputs();

        // Randomised traffic with a small register range to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            RESET        = ($urandom_range(0, 199) == 0);
            ic_busy      = ($urandom_range(0, 11) == 0);
            dc_busy      = ($urandom_range(0, 11) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            ex_memRead = 1'($urandom); ex_regWrite = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 3)); mem_regWrite = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_regWrite = 1'($urandom);
            step();
        end

        done = 1'b1;
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
